// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//
// Contents:
//   state_t  - controller state for the serial subtractor, 2-bit binary
//              encoding (IDLE, RUN, DONE)
//   cnt_w()  - width of the bit counter needed to address WIDTH bit positions

package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    // The guard keeps the width at least one bit for degenerate widths.
    function automatic int cnt_w(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: computes a - b - bin.
//
// Ports:
//   a     in   1  minuend bit
//   b     in   1  subtrahend bit
//   bin   in   1  borrow in from the less significant bit
//   d     out  1  difference bit
//   bout  out  1  borrow out to the more significant bit

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d = a ^ b ^ bin;

    // Borrow when the minuend bit is 0 against a 1, or when the bits are
    // equal and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock:
//   diff = a - b mod 2^WIDTH, borrow_out = 1 iff a < b.
// A single full_subtractor cell is reused for every bit position.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   start       in   1      request, accepted only while ready=1
//   a           in   WIDTH  minuend, sampled on the accepting edge
//   b           in   WIDTH  subtrahend, sampled on the accepting edge
//   ready       out  1      high in IDLE
//   busy        out  1      high in RUN and DONE
//   done        out  1      one-cycle completion pulse
//   diff        out  WIDTH  registered result
//   borrow_out  out  1      registered final borrow

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_sr_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;

    logic             cell_d;
    logic             cell_bo;
    logic             load;
    logic             shift;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // The result assembles from the top down so that after WIDTH shifts
    // the first (LSB) difference bit has arrived at position 0.
    assign diff_sr_nxt = {cell_d, diff_sr[WIDTH-1:1]};
    assign last_bit    = (state == RUN) && (cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. start is only looked at in IDLE,
    // so requests arriving while busy are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand shift registers, borrow flop, bit counter and the
    // result registers. diff/borrow_out are written only on the final bit
    // so they hold the previous result throughout RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (shift) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= diff_sr_nxt;
            brw     <= cell_bo;
            cnt     <= last_bit ? '0 : cnt + CW'(1);
            if (last_bit) begin
                diff       <= diff_sr_nxt;
                borrow_out <= cell_bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Stimulus pushes expected results into a scoreboard queue; a monitor
// pops and compares whenever done is seen.

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        int               acc;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit b2b          = 0;
    bit prev_ok      = 0;
    int prev_done    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time latency and done spacing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL wait_ready: ready=%0b, expected 1", ready);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL wait_done: done=%0b, expected 1", done);
        end
    endtask

    // Waits for ready, drives one request and records its expected result.
    // With hold=1 start is left high for back-to-back operation.
    task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic [WIDTH-1:0] exp_d, input logic exp_b,
                                  input bit hold);
        exp_t e;
        wait_ready();
        start = 1'b1;
        a     = av;
        b     = bv;
        e.d   = exp_d;
        e.bo  = exp_b;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_output("ready_in_run", ready, 0);
        check_output("busy_in_run", busy, 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                check_output("diff", diff, e.d);
                check_output("borrow_out", borrow_out, e.bo);
                check_output("latency", cyc - e.acc, WIDTH);
            end
            if (b2b) begin
                if (prev_ok) check_output("done_spacing", cyc - prev_done, WIDTH + 2);
                prev_done = cyc;
                prev_ok   = 1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH:0]   wide;
        int               n;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_ready", ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_diff", diff, 0);
        check_output("reset_borrow", borrow_out, 0);
        rst_n = 1'b1;

        // Directed vectors.
        apply_stimulus(8'd200, 8'd55,  8'd145,  1'b0, 0);
        apply_stimulus(8'd5,   8'd10,  8'd251,  1'b1, 0);
        apply_stimulus(8'd0,   8'hFF,  8'd1,    1'b1, 0);
        apply_stimulus(8'h80,  8'h80,  8'd0,    1'b0, 0);
        apply_stimulus(8'hFF,  8'h00,  8'hFF,   1'b0, 0);

        // start held high, operands changed during RUN.
        apply_stimulus(8'd50, 8'd20, 8'd30, 1'b0, 1);
        a = 8'd7;
        b = 8'd9;
        wait_done();
        check_output("ready_during_done", ready, 0);
        begin
            exp_t e2;
            e2.d   = 8'd254;
            e2.bo  = 1'b1;
            e2.acc = cyc + 2;
            sb.push_back(e2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_output("second_accept_busy", busy, 1);
        wait_done();

        // Reset during RUN cycle 4 aborts the operation.
        apply_stimulus(8'd100, 8'd1, 8'd99, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_output("abort_ready", ready, 1);
        check_output("abort_busy", busy, 0);
        check_output("abort_diff", diff, 0);
        check_output("abort_borrow", borrow_out, 0);
        repeat (12) @(negedge clk);
        apply_stimulus(8'd9, 8'd3, 8'd6, 1'b0, 0);
        wait_done();

        // Back-to-back with start tied high.
        prev_ok = 0;
        b2b     = 1;
        for (int i = 0; i < 100; i++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            wide = {1'b0, ra} - {1'b0, rb};
            apply_stimulus(ra, rb, wide[WIDTH-1:0], (ra < rb), 1);
        end
        start = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("scoreboard_empty", sb.size(), 0);
        b2b = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
